// File: rtl/ecall_io_ctrl_if.sv
// rtl/ecall_io_ctrl_if.sv - ECALL I/O controller signal bundle
// Purpose: groups the core-side, board-side and register-file-side signals.
// Ports (master = core/board side, slave = controller):
//   ecall_valid, a7              : decoded ECALL flag and syscall selector
//   confirm_btn, switch          : raw asynchronous board inputs
//   key_valid, key_code          : synchronous keypad strobe and code
//   stop_flag, halted            : freeze request and program-exit flag
//   io_we, io_waddr, io_wdata    : one-cycle register file write request
//   kb_value                     : live keypad accumulator
interface ecall_io_ctrl_if;
    logic        ecall_valid;
    logic [31:0] a7;
    logic        confirm_btn;
    logic [7:0]  switch;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        stop_flag;
    logic        io_we;
    logic [4:0]  io_waddr;
    logic [31:0] io_wdata;
    logic [31:0] kb_value;
    logic        halted;

    modport master (
        output ecall_valid, a7, confirm_btn, switch, key_valid, key_code,
        input  stop_flag, io_we, io_waddr, io_wdata, kb_value, halted
    );

    modport slave (
        input  ecall_valid, a7, confirm_btn, switch, key_valid, key_code,
        output stop_flag, io_we, io_waddr, io_wdata, kb_value, halted
    );
endinterface

// File: rtl/ecall_io_ctrl.sv
// rtl/ecall_io_ctrl.sv - ECALL input path controller for the register file
// Purpose: freezes the core on ECALL, collects switch or keypad input,
//   waits for a debounced confirm press, issues one register write and
//   releases the core once the button is let go. a7==10 halts permanently.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ecall_io_ctrl_if.slave (see interface file for signal list)
module ecall_io_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic           clk,
    input  logic           reset,
    ecall_io_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        WRITE   = 3'd2,
        RELEASE = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_btn_s1;
    logic        r_btn_s2;
    logic [7:0]  r_sw_s1;
    logic [7:0]  r_sw_s2;
    logic        r_btn_db;
    logic [CNT_W-1:0] r_db_cnt;

    logic        r_mode;
    logic [31:0] r_acc;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    logic        w_db_toggle;
    logic        w_btn_rise;
    logic        w_start_in;
    logic        w_start_halt;
    logic        w_key_apply;
    logic [31:0] w_acc_key;
    logic [31:0] w_acc_cap;
    logic        w_stop;
    logic        w_we;
    logic        w_halted;

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= 8'h00;
            r_sw_s2  <= 8'h00;
        end else begin
            r_btn_s1 <= bus.confirm_btn;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= bus.switch;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // The debounced level only follows the synced button after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    assign w_db_toggle = (r_btn_s2 != r_btn_db) && (r_db_cnt == DB_LAST);
    // Rise is flagged in the cycle the level is about to go high, so the
    // FSM reacts on the same edge the debounced level changes.
    assign w_btn_rise  = w_db_toggle && !r_btn_db;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_btn_s2 == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (w_db_toggle) begin
            r_btn_db <= ~r_btn_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_start_in   = bus.ecall_valid && ((bus.a7 == 32'd0) || (bus.a7 == 32'd1));
    assign w_start_halt = bus.ecall_valid && (bus.a7 == 32'd10);

    // Keypad edit of the accumulator; codes above 0xB leave it unchanged.
    always_comb begin
        w_acc_key = r_acc;
        if (bus.key_code <= 4'd9) begin
            w_acc_key = (r_acc * 32'd10) + {28'h0, bus.key_code};
        end else if (bus.key_code == 4'hA) begin
            w_acc_key = r_acc / 32'd10;
        end else if (bus.key_code == 4'hB) begin
            w_acc_key = 32'd0;
        end
    end

    assign w_key_apply = (r_state == WAIT_IN) && r_mode && bus.key_valid;
    // A key arriving with the confirm rise is folded in before capture.
    assign w_acc_cap   = w_key_apply ? w_acc_key : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stop       = (r_state != IDLE);
        w_we         = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            IDLE: begin
                // Combinational stop freezes the PC in the decode cycle.
                if (w_start_in) begin
                    w_state_next = WAIT_IN;
                    w_stop       = 1'b1;
                end else if (w_start_halt) begin
                    w_state_next = HALT;
                    w_stop       = 1'b1;
                end
            end
            WAIT_IN: begin
                if (w_btn_rise) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_we         = 1'b1;
                w_state_next = RELEASE;
            end
            RELEASE: begin
                // Wait for the debounced release so one press is one ECALL.
                if (!r_btn_db) begin
                    w_state_next = IDLE;
                end
            end
            HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= 1'b0;
            r_acc  <= 32'd0;
        end else if ((r_state == IDLE) && w_start_in) begin
            r_mode <= bus.a7[0];
            r_acc  <= 32'd0;
        end else if (w_key_apply) begin
            r_acc  <= w_acc_key;
        end
    end

    // Write address/data are loaded on entry to WRITE and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else if ((r_state == WAIT_IN) && w_btn_rise) begin
            if (r_mode) begin
                r_waddr <= 5'd10;
                r_wdata <= w_acc_cap;
            end else begin
                r_waddr <= 5'd8;
                r_wdata <= {24'h0, r_sw_s2};
            end
        end
    end

    assign bus.stop_flag = w_stop;
    assign bus.io_we     = w_we;
    assign bus.io_waddr  = r_waddr;
    assign bus.io_wdata  = r_wdata;
    assign bus.kb_value  = r_acc;
    assign bus.halted    = w_halted;

endmodule

// File: doc/ecall_io_ctrl.md
Name: ecall_io_ctrl

Overview:
- Upstream controller for the register file's ECALL input path.
- When the core decodes an ECALL, this block freezes the core by asserting stop_flag.
- While frozen, it collects operator input from the board switches or the keypad, then waits for a debounced confirm press.
- It then issues a one-cycle register write request carrying the captured value, and releases the core only after the button is let go.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced button level changes.
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ecall_valid  input  1  decoder flag: the current instruction is ECALL.
- a7  input  32  current value of x17, the syscall selector.
- confirm_btn  input  1  raw, asynchronous confirm push-button.
- switch  input  8  raw board switches.
- key_valid  input  1  single-cycle strobe from the keypad scanner.
- key_code  input  4  keypad code: 0-9 digit, 0xA backspace, 0xB clear, others ignored.
- stop_flag  output  1  freeze request to PC and register file.
- io_we  output  1  one-cycle write request to the register file.
- io_waddr  output  5  destination register of the write.
- io_wdata  output  32  data to write.
- kb_value  output  32  live keypad accumulator, for tube display.
- halted  output  1  program exit reached (a7==10).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; stop_flag, io_we, halted = 0; io_waddr=0, io_wdata=0, kb_value=0; synchronizers, debounced level and counter all 0.
- Input sync: confirm_btn and switch each pass through 2 flops before use. key_valid/key_code are already synchronous.
- Debounce:
  - Counter resets to 0 whenever the synced button equals the debounced level; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level toggles and the counter returns to 0.
  - btn_rise is a single-cycle pulse on the debounced 0->1 transition.
- Handled syscalls are a7 = 0, 1, 10. Any other a7 with ecall_valid is a no-op: state stays IDLE, stop_flag stays 0.
- stop_flag = (state != IDLE) OR (state==IDLE AND ecall_valid AND a7 is handled). The combinational term freezes the PC in the decode cycle itself.
- FSM states: IDLE, WAIT_IN, WRITE, RELEASE, HALT.
  - IDLE -> WAIT_IN when ecall_valid and a7 is 0 or 1. Latch mode = a7[0]; clear the accumulator to 0.
  - IDLE -> HALT when ecall_valid and a7==10.
  - WAIT_IN, mode 1, key_valid:
    - digit d: acc = acc*10 + d, 32-bit, wraps modulo 2^32.
    - 0xA: acc = acc/10 (unsigned).
    - 0xB: acc = 0.
    - other codes: ignored.
  - key_valid in mode 0 or in any other state is ignored.
  - WAIT_IN -> WRITE on btn_rise. If a key strobe and btn_rise occur in the same cycle, the key is applied first and the updated acc is captured.
  - WRITE lasts exactly one cycle, with io_we=1:
    - mode 0: io_waddr=8, io_wdata={24'h0, synced switch}.
    - mode 1: io_waddr=10, io_wdata=acc.
  - WRITE -> RELEASE unconditionally.
  - RELEASE -> IDLE when the debounced level is 0, so one press completes exactly one ECALL.
  - HALT: stop_flag=1 and halted=1 permanently; only reset exits.
- Output timing: io_we is 0 in every state except WRITE. io_waddr and io_wdata hold their last values outside WRITE.
- kb_value continuously mirrors acc.
- A confirm press already held when the ECALL arrives does not count; a fresh debounced rise is required.
- Reset asserted mid-operation returns everything to reset values immediately, with no write issued.
- ecall_valid while the state is not IDLE is ignored; the core is frozen and presents the same instruction.

Test Plan:
- DEBOUNCE_CYCLES=4.
  - Stimulus: switch=8'hA5, a7=0, pulse ecall_valid, hold confirm_btn high for 10 cycles, then low.
  - Required: stop_flag=1 from the ecall cycle; exactly one io_we cycle with waddr=8, wdata=32'h000000A5; stop_flag drops after the debounced release.
- Keypad entry:
  - Stimulus: a7=1, ECALL, keys 1,2,3, 0xA, 7, then confirm.
  - Required: kb_value steps 1,12,123,12,127; write waddr=10, wdata=127.
- Glitch rejection:
  - Stimulus: confirm pulses of 2 cycles while in WAIT_IN.
  - Required: no btn_rise, no io_we, stop_flag stays 1.
- Unhandled and exit syscalls:
  - Stimulus: ECALL with a7=5.
  - Required: stop_flag never 1, no write.
  - Stimulus: ECALL with a7=10.
  - Required: halted=1 and stop_flag=1, held through 100 cycles of button activity.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT_IN, with acc=42.
  - Required: all outputs 0 asynchronously, kb_value=0, state IDLE; a new ECALL works normally.
- Simultaneous events and wrap:
  - Stimulus: key 9 coincident with btn_rise, acc=4.
  - Required: wdata=49.
  - Stimulus: acc=429496729 followed by key 6.
  - Required: acc wraps to 0.
